pipelined_csel_addsub: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor for the datapath ALU; the next generation of the fixed 32-bit combinational carry-select adder.
- WIDTH, carry-select block size and pipeline depth are generic.
- Adds subtract mode, signed-overflow and zero flags, a valid/ready handshake with full backpressure, and a synchronous flush.
- Sits between operand select and the result writeback mux.

---
 rtl/pipelined_csel_addsub.sv | 155 +++++++++++++++
 tb/tb_pipelined_csel_addsub.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select adder/subtractor with valid/ready backpressure and flush.
// WIDTH/BLOCK blocks are split into STAGES equal segments, one segment resolved per stage.

module pipelined_csel_addsub_blk #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  output logic [BLOCK-1:0] o_s0,
  output logic [BLOCK-1:0] o_s1,
  output logic             o_c0,
  output logic             o_c1
);
  assign {o_c0, o_s0} = {1'b0, i_a} + {1'b0, i_b};
  assign {o_c1, o_s1} = {1'b0, i_a} + {1'b0, i_b} + {{BLOCK{1'b0}}, 1'b1};
endmodule

module pipelined_csel_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);
  localparam int NB  = WIDTH / BLOCK;
  localparam int BPS = NB / STAGES;
  localparam int SW  = BPS * BLOCK;

  logic [WIDTH-1:0]  w_bp;
  logic              w_c0;
  logic [STAGES-1:0] r_vld;
  logic [STAGES:0]   w_vld_pipe, w_rdy;

  assign w_bp       = sub ? ~b : b;
  assign w_c0       = ci ^ sub;
  assign w_vld_pipe = {r_vld, in_valid};
  assign out_valid  = w_vld_pipe[STAGES];
  assign in_ready   = w_rdy[0];

  // A stage may take a new beat when empty or when its own beat moves on.
  always_comb begin
    w_rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      w_rdy[k] = !r_vld[k] || w_rdy[k+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_vld <= '0;
    else if (flush) r_vld <= '0;
    else begin
      for (int k = 0; k < STAGES; k++)
        if (w_rdy[k]) r_vld[k] <= w_vld_pipe[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic [WIDTH-1:LO]         w_a, w_b;
    logic                      w_ci, w_co, w_ld;
    logic [BPS-1:0][BLOCK-1:0] w_s0, w_s1;
    logic [BPS-1:0]            w_k0, w_k1;
    logic [SW-1:0]             w_seg;
    logic [HI-1:0]             w_sum, r_s;
    logic                      r_c;

    assign w_ld = w_rdy[k] && w_vld_pipe[k];

    if (k == 0) begin : g_head
      assign w_a   = a;
      assign w_b   = w_bp;
      assign w_ci  = w_c0;
      assign w_sum = w_seg;
    end else begin : g_body
      assign w_a   = g_stg[k-1].g_fwd.r_a;
      assign w_b   = g_stg[k-1].g_fwd.r_b;
      assign w_ci  = g_stg[k-1].r_c;
      assign w_sum = {w_seg, g_stg[k-1].r_s};
    end

    pipelined_csel_addsub_blk #(.BLOCK(BLOCK)) u_blk [BPS-1:0] (
      .i_a  (w_a[HI-1:LO]),
      .i_b  (w_b[HI-1:LO]),
      .o_s0 (w_s0),
      .o_s1 (w_s1),
      .o_c0 (w_k0),
      .o_c1 (w_k1)
    );

    // Carry ripples only through the select muxes; block sums are precomputed.
    always_comb begin : p_sel
      logic c;
      c     = w_ci;
      w_seg = '0;
      for (int j = 0; j < BPS; j++) begin
        w_seg[j*BLOCK +: BLOCK] = c ? w_s1[j] : w_s0[j];
        c                       = c ? w_k1[j] : w_k0[j];
      end
      w_co = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_ld) begin
        r_s <= w_sum;
        r_c <= w_co;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI] r_a, r_b;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ld) begin
          r_a <= w_a[WIDTH-1:HI];
          r_b <= w_b[WIDTH-1:HI];
        end
      end
    end else begin : g_tail
      logic r_ovf, r_zero;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_ld) begin
          r_ovf  <= (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
          r_zero <= ~|w_sum;
        end
      end
      assign s    = r_s;
      assign co   = r_c;
      assign ovf  = r_ovf;
      assign zero = r_zero;
    end
  end
endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// Scoreboard bench: default 32/4/2 instance with handshake/flush/reset scenarios,
// plus 8/2/4 (exhaustive operands) and 64/8/1 (random) instances streaming.
module tb_pipelined_csel_addsub;
  localparam int W   = 32;
  localparam int STG = 2;

  typedef struct packed {logic co; logic ovf; logic zero; logic [63:0] s;} res_t;
  typedef struct {res_t r; int c; logic lat;} ent_t;

  logic          clk = 0, rst_n = 0, flush = 0, in_valid = 0, ci = 0, sub = 0, out_ready = 1;
  logic [W-1:0]  a = '0, b = '0, s;
  logic          in_ready, out_valid, co, ovf, zero;

  logic          sw_iv = 0, sw_ci = 0, sw_sub = 0;
  logic [7:0]    a8 = '0, b8 = '0, s8;
  logic [63:0]   a64 = '0, b64 = '0, s64;
  logic          rdy8, ov8, co8, ovf8, z8, rdy64, ov64, co64, ovf64, z64;

  always #5 clk = ~clk;

  pipelined_csel_addsub #(.WIDTH(W), .BLOCK(4), .STAGES(STG)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf), .zero(zero));

  pipelined_csel_addsub #(.WIDTH(8), .BLOCK(2), .STAGES(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(sw_iv), .in_ready(rdy8),
    .a(a8), .b(b8), .ci(sw_ci), .sub(sw_sub), .out_valid(ov8), .out_ready(1'b1),
    .s(s8), .co(co8), .ovf(ovf8), .zero(z8));

  pipelined_csel_addsub #(.WIDTH(64), .BLOCK(8), .STAGES(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(sw_iv), .in_ready(rdy64),
    .a(a64), .b(b64), .ci(sw_ci), .sub(sw_sub), .out_valid(ov64), .out_ready(1'b1),
    .s(s64), .co(co64), .ovf(ovf64), .zero(z64));

  int   n_chk = 0, n_err = 0, cyc = 0;
  logic lat_chk = 0, acc = 0;
  ent_t q[$], q8[$], q64[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic res_t model(input int w, input logic [63:0] x, y, input logic c, sb);
    logic [64:0] msk, sum;
    logic [63:0] xm, yp;
    res_t r;
    msk   = (65'd1 << w) - 65'd1;
    xm    = x & msk[63:0];
    yp    = (sb ? ~y : y) & msk[63:0];
    sum   = {1'b0, xm} + {1'b0, yp} + {64'd0, c ^ sb};
    r.s   = sum[63:0] & msk[63:0];
    r.co  = sum[w];
    r.ovf = (xm[w-1] == yp[w-1]) && (r.s[w-1] != xm[w-1]);
    r.zero = (r.s == 64'd0);
    return r;
  endfunction

  // One cycle on the main DUT: drive at negedge, then score what the next posedge does.
  task automatic step(input logic iv, input logic [W-1:0] ia, ib, input logic ic, isb, ord, fl,
                      output logic ok);
    @(negedge clk);
    cyc++;
    in_valid = iv; a = ia; b = ib; ci = ic; sub = isb; out_ready = ord; flush = fl;
    #1;
    chk("in_ready", in_ready, !(q.size() == STG && !ord));
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        chk("result", {co, ovf, zero, 64'(s)}, q[0].r);
        if (q[0].lat) begin
          chk("latency", cyc - q[0].c, STG);
          q[0].lat = 1'b0;
        end
        if (ord) q.delete(0);
      end
    end
    ok = iv && in_ready && !fl;
    if (fl) q.delete();
    else if (ok) q.push_back('{model(W, 64'(ia), 64'(ib), ic, isb), cyc, lat_chk});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  logic [W-1:0] da [5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000, 32'd3};
  logic [W-1:0] db [5] = '{32'h00000001, 32'h00000001, 32'd7, 32'h00000001, 32'd3};
  logic         dc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic         ds [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_outputs", {co, ovf, zero, s}, '0);
    @(negedge clk);
    rst_n = 1;

    // Directed arithmetic corners, back to back, latency checked
    lat_chk = 1;
    for (int i = 0; i < 5; i++) step(1'b1, da[i], db[i], dc[i], ds[i], 1'b1, 1'b0, acc);
    idle(STG + 2);
    chk("directed_drain", q.size(), 0);

    // Random stream under random backpressure
    lat_chk = 0;
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++)
        step(1'b1, ra, rb, rc, rs, 1'($urandom_range(0, 1)), 1'b0, acc);
      if (!acc) chk("accept_timeout", acc, 1'b1);
    end
    for (int t = 0; t < 20 && q.size() > 0; t++) idle(1);
    chk("stream_drain", q.size(), 0);

    // Flush with a full, stalled pipe and a beat presented alongside
    step(1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'h33333333, 32'h44444444, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 32'h55555555, 32'h66666666, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    idle(1);
    chk("flush_out_valid", out_valid, 1'b0);
    lat_chk = 1;
    step(1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    idle(STG + 2);
    chk("flush_drain", q.size(), 0);

    // Flush while a new beat would otherwise be accepted
    step(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 32'hDEADBEEF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    idle(1);
    chk("flush2_out_valid", out_valid, 1'b0);
    idle(STG + 2);

    // Asynchronous reset with two beats in flight
    lat_chk = 0;
    step(1'b1, 32'hAAAA0000, 32'h0000AAAA, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, acc);
    @(posedge clk);
    #2;
    rst_n = 0;
    in_valid = 0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_outputs", {co, ovf, zero, s}, '0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    idle(STG + 3);

    // Parameter sweep: 8-bit exhaustive operands and 64-bit random, single-cycle stream
    for (int i = 0; i < 65536 + 8; i++) begin
      @(negedge clk);
      cyc++;
      sw_iv = (i < 65536);
      a8 = 8'(i >> 8); b8 = 8'(i);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      sw_ci = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
      #1;
      if (i % 4096 == 0) begin
        chk("rdy8", rdy8, 1'b1);
        chk("rdy64", rdy64, 1'b1);
      end
      if (ov8) begin
        if (q8.size() == 0) chk("spurious8", ov8, 1'b0);
        else begin
          chk("res8", {co8, ovf8, z8, 64'(s8)}, q8[0].r);
          chk("lat8", cyc - q8[0].c, 4);
          q8.delete(0);
        end
      end
      if (ov64) begin
        if (q64.size() == 0) chk("spurious64", ov64, 1'b0);
        else begin
          chk("res64", {co64, ovf64, z64, s64}, q64[0].r);
          chk("lat64", cyc - q64[0].c, 1);
          q64.delete(0);
        end
      end
      if (sw_iv) begin
        q8.push_back('{model(8, 64'(a8), 64'(b8), sw_ci, sw_sub), cyc, 1'b1});
        q64.push_back('{model(64, a64, b64, sw_ci, sw_sub), cyc, 1'b1});
      end
    end
    chk("drain8", q8.size(), 0);
    chk("drain64", q64.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
